// File: rtl/log_fp_mult_stream.sv
// log_fp_mult_stream
//   Byte-serial logarithmic (Mitchell-style) floating-point multiplier.
//   Operands arrive as NB little-endian beats, are multiplied by adding
//   their log-domain mantissas (with an optional piecewise-linear
//   correction), and the packed result leaves as NB little-endian beats.
//   Zero/subnormal inputs flush to zero; Inf, NaN, overflow and underflow
//   are handled with status flags.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid            in_ready  block accepts a beat
//   a_in/b_in  operand beats, little-endian  mode      1 = corrected log/antilog
//   out_valid  result beat valid             out_ready sink accepts a beat
//   out_data   result beat, little-endian    out_last  final beat of the word
//   flags      {nan, ovf, unf, zero}, held for every beat of a word
module log_fp_mult_stream #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] a_in,
  input  logic [BUS_W-1:0] b_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic [3:0]       flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int NB = (W + BUS_W - 1) / BUS_W;
  localparam int WB = NB * BUS_W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int EW = EXP_W + 2;

  localparam logic [IW-1:0]    LAST_IDX = IW'(NB - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0]    BIAS_E   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    E_MAX    = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN     =
    W'((((1 << EXP_W) - 1) << MAN_W) | (1 << (MAN_W - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_DECODE, S_LOG, S_ADD, S_ANTILOG, S_PACK, S_OUTPUT
  } state_e;

  state_e state_q, state_d;

  // Control and output registers (reset)
  logic [IW-1:0] idx_q;
  logic          in_ready_q, out_valid_q, out_last_q;
  logic [WB-1:0] res_q;
  logic [3:0]    flags_q;

  // Datapath pipeline registers (not reset)
  logic [WB-1:0]    a_sh_q, b_sh_q;
  logic             mode_q, sign_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [MAN_W-1:0] ma_q, mb_q, la_q, lb_q, mant_q;
  logic [MAN_W:0]   s_q;
  logic [EW-1:0]    e_q;

  logic [W-1:0] res_d;
  logic [3:0]   flags_d;
  logic         accept_in, accept_out;

  // Correction term: distance to the nearer end of the mantissa range,
  // scaled by 3/16. Never exceeds 3/16 of x, so x + corr and x - corr
  // both stay inside MAN_W bits.
  function automatic logic [MAN_W-1:0] corr(input logic [MAN_W-1:0] x,
                                            input logic md);
    logic [MAN_W:0] cx, t;
    cx = {1'b1, {MAN_W{1'b0}}} - {1'b0, x};
    t  = ({1'b0, x} < cx) ? {1'b0, x} : cx;
    return md ? MAN_W'((t >> 3) + (t >> 4)) : '0;
  endfunction

  // in_ready_q is only high in IDLE/COLLECT, and stays low for the cycle
  // after reset even though the state is already IDLE.
  assign accept_in  = in_valid && in_ready_q;
  assign accept_out = (state_q == S_OUTPUT) && out_ready;

  // NOTE: every variable in a combinational block gets a default before
  // any branch, so no path can leave it holding a value (no latches).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_COLLECT:
        if (accept_in) state_d = (idx_q == LAST_IDX) ? S_DECODE : S_COLLECT;
      S_DECODE:  state_d = S_LOG;
      S_LOG:     state_d = S_ADD;
      S_ADD:     state_d = S_ANTILOG;
      S_ANTILOG: state_d = S_PACK;
      S_PACK:    state_d = S_OUTPUT;
      S_OUTPUT:
        if (out_ready && idx_q == LAST_IDX) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Special-case resolution, highest priority first.
  always_comb begin
    logic a_ones, b_ones, a_zero, b_zero, a_nan, b_nan;
    a_ones  = (ea_q == EXP_ONES);
    b_ones  = (eb_q == EXP_ONES);
    a_zero  = (ea_q == '0);
    b_zero  = (eb_q == '0);
    a_nan   = a_ones && (ma_q != '0);
    b_nan   = b_ones && (mb_q != '0);
    res_d   = {sign_q, e_q[EXP_W-1:0], mant_q};
    flags_d = 4'b0000;
    if ((a_ones && b_zero) || (b_ones && a_zero) || a_nan || b_nan) begin
      res_d   = QNAN;
      flags_d = 4'b1000;
    end else if (a_ones || b_ones) begin
      res_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      res_d   = {sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0001;
    end else if (!e_q[EW-1] && e_q >= E_MAX) begin
      res_d   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0100;
    end else if (e_q[EW-1] || e_q == '0) begin
      res_d   = {sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_IDLE) || (state_d == S_COLLECT);
      out_valid_q <= (state_d == S_OUTPUT);
      if (accept_in) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      if (state_q == S_PACK) begin
        res_q      <= WB'(res_d);
        flags_q    <= flags_d;
        out_last_q <= (NB == 1);
      end
      // The result shifts down one beat per accepted output beat, so the
      // next beat is already in the output register when it is presented.
      if (accept_out) begin
        res_q <= res_q >> BUS_W;
        if (idx_q == LAST_IDX) begin
          idx_q      <= '0;
          out_last_q <= 1'b0;
        end else begin
          idx_q      <= idx_q + 1'b1;
          out_last_q <= (idx_q + 1'b1 == LAST_IDX);
        end
      end
    end
  end

  // NOTE: pipeline data registers carry no reset; every one is rewritten by
  // its own stage before it is read, and reset only has to clear control.
  always_ff @(posedge clk) begin
    if (accept_in) begin
      // Beats arrive low-first; shifting in from the top leaves beat k at
      // bits [k*BUS_W +: BUS_W] once all NB beats are in.
      a_sh_q <= (a_sh_q >> BUS_W) | (WB'(a_in) << (WB - BUS_W));
      b_sh_q <= (b_sh_q >> BUS_W) | (WB'(b_in) << (WB - BUS_W));
      if (state_q == S_IDLE) mode_q <= mode;
    end
    unique case (state_q)
      S_DECODE: begin
        sign_q <= a_sh_q[W-1] ^ b_sh_q[W-1];
        ea_q   <= a_sh_q[W-2 -: EXP_W];
        eb_q   <= b_sh_q[W-2 -: EXP_W];
        ma_q   <= a_sh_q[MAN_W-1:0];
        mb_q   <= b_sh_q[MAN_W-1:0];
      end
      S_LOG: begin
        la_q <= ma_q + corr(ma_q, mode_q);
        lb_q <= mb_q + corr(mb_q, mode_q);
      end
      S_ADD: s_q <= {1'b0, la_q} + {1'b0, lb_q};
      S_ANTILOG: begin
        mant_q <= s_q[MAN_W-1:0] - corr(s_q[MAN_W-1:0], mode_q);
        // Two's-complement in EW bits; a set top bit means E < 0.
        e_q    <= {2'b00, ea_q} + {2'b00, eb_q} - BIAS_E + EW'(s_q[MAN_W]);
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q[BUS_W-1:0];
  assign out_last  = out_last_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_log_fp_mult_stream.sv
// Testbench for log_fp_mult_stream: an fp16 instance (default parameters)
// and a bf16 instance (EXP_W=8, MAN_W=7). Expected output beats are queued
// when a word is driven and compared when the DUT presents them.
module tb_log_fp_mult_stream;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] flags;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, mode, out_ready, in_ready, out_valid, out_last;
  logic [7:0] a_in, b_in, out_data;
  logic [3:0] flags;
  logic       in_valid_b, mode_b, out_ready_b, in_ready_b, out_valid_b, out_last_b;
  logic [7:0] a_in_b, b_in_b, out_data_b;
  logic [3:0] flags_b;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t sb[$];
  beat_t sb_b[$];

  always #5 clk = ~clk;

  log_fp_mult_stream u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .flags(flags)
  );

  log_fp_mult_stream #(.EXP_W(8), .MAN_W(7), .BUS_W(8)) u_bf (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .a_in(a_in_b), .b_in(b_in_b), .mode(mode_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b),
    .flags(flags_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference fp16 model, returns {flags, result}.
  function automatic int cor16(input int x, input bit md);
    int t;
    t = (x < 1024 - x) ? x : 1024 - x;
    return md ? (t >> 3) + (t >> 4) : 0;
  endfunction

  function automatic logic [19:0] model16(input logic [15:0] a, input logic [15:0] b, input bit md);
    int ea, eb, ma, mb, s, c, f, mant, e;
    bit sg;
    sg = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]);   mb = int'(b[9:0]);
    s  = ma + cor16(ma, md) + mb + cor16(mb, md);
    c  = s / 1024;
    f  = s % 1024;
    mant = f - cor16(f, md);
    e  = ea + eb - 15 + c;
    if ((ea == 31 && eb == 0) || (eb == 31 && ea == 0) ||
        (ea == 31 && ma != 0) || (eb == 31 && mb != 0)) return {4'b1000, 16'h7E00};
    if (ea == 31 || eb == 31) return {4'b0000, sg, 15'h7C00};
    if (ea == 0 || eb == 0)   return {4'b0001, sg, 15'h0000};
    if (e >= 31)              return {4'b0100, sg, 15'h7C00};
    if (e <= 0)               return {4'b0011, sg, 15'h0000};
    return {4'b0000, sg, 5'(e), 10'(mant)};
  endfunction

  task automatic mon_one(input bit bf);
    beat_t obs;
    int    sz;
    obs = bf ? {out_data_b, out_last_b, flags_b} : {out_data, out_last, flags};
    sz  = bf ? sb_b.size() : sb.size();
    vectors++;
    assert (sz != 0) else begin
      miscompares++;
      $error("FAIL %s unexpected beat: observed %h expected none", bf ? "bf16" : "fp16", obs);
    end
    if (sz != 0) begin
      if (bf) begin
        check("bf16 beat {data,last,flags}", 32'(obs), 32'(sb_b[0]));
        if (out_ready_b) void'(sb_b.pop_front());
      end else begin
        check("fp16 beat {data,last,flags}", 32'(obs), 32'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
      vectors--;  // the presence test above and the value check are one vector
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid)   mon_one(1'b0);
        if (out_valid_b) mon_one(1'b1);
      end
    end
  endtask

  task automatic wait_ready(input bit bf);
    int   n;
    logic rdy;
    n = 0;
    @(negedge clk);
    rdy = bf ? in_ready_b : in_ready;
    while (!rdy && n < 300) begin
      @(negedge clk);
      rdy = bf ? in_ready_b : in_ready;
      n++;
    end
    check(bf ? "in_ready_b wait" : "in_ready wait", 32'(rdy), 32'd1);
  endtask

  // Starts and ends just after a rising edge.
  task automatic send_word(input bit bf, input logic [15:0] a, input logic [15:0] b,
                           input bit md, input int gap, input bit flip, input bit push,
                           input logic [15:0] exp_res, input logic [3:0] exp_fl);
    if (push) begin
      if (bf) begin
        sb_b.push_back({exp_res[7:0], 1'b0, exp_fl});
        sb_b.push_back({exp_res[15:8], 1'b1, exp_fl});
      end else begin
        sb.push_back({exp_res[7:0], 1'b0, exp_fl});
        sb.push_back({exp_res[15:8], 1'b1, exp_fl});
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (bf) begin
        a_in_b = a[k*8 +: 8]; b_in_b = b[k*8 +: 8]; in_valid_b = 1'b1;
        mode_b = (k != 0 && flip) ? ~md : md;
      end else begin
        a_in = a[k*8 +: 8]; b_in = b[k*8 +: 8]; in_valid = 1'b1;
        mode = (k != 0 && flip) ? ~md : md;
      end
      wait_ready(bf);
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      in_valid_b = 1'b0;
      if (k == 0) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int          n;
    logic [15:0] ra, rb;
    bit          rm;
    logic [19:0] r;

    rst = 1'b1;
    in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    in_valid_b = 1'b0; mode_b = 1'b0; out_ready_b = 1'b1; a_in_b = '0; b_in_b = '0;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready after reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 2.0 * 3.0 = 6.0, with latency check
    send_word(0, 16'h4000, 16'h4200, 0, 0, 0, 1, 16'h4600, 4'b0000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("out_valid 4 after accept", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("out_valid 5 after accept", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Main function and special cases, back to back
    send_word(0, 16'h3E00, 16'h3E00, 1, 0, 0, 1, 16'h409C, 4'b0000);
    send_word(0, 16'h3E00, 16'h3E00, 0, 0, 0, 1, 16'h4000, 4'b0000);
    send_word(0, 16'h0000, 16'h3C00, 0, 0, 0, 1, 16'h0000, 4'b0001);
    send_word(0, 16'hBC00, 16'h3C00, 0, 0, 0, 1, 16'hBC00, 4'b0000);
    send_word(0, 16'h7800, 16'h7800, 0, 0, 0, 1, 16'h7C00, 4'b0100);
    send_word(0, 16'h0400, 16'h0400, 0, 0, 0, 1, 16'h0000, 4'b0011);
    send_word(0, 16'h7C00, 16'h0000, 1, 0, 0, 1, 16'h7E00, 4'b1000);

    // Mode changes mid-word must be ignored
    send_word(0, 16'h3E00, 16'h3E00, 1, 0, 1, 1, 16'h409C, 4'b0000);

    // Input gap between beats and a 3-cycle output stall on beat 0
    wait_ready(0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_word(0, 16'h4000, 16'h4200, 0, 2, 0, 1, 16'h4600, 4'b0000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("stall out_valid", 32'(out_valid), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset during ANTILOG discards the word
    send_word(0, 16'h4000, 16'h4200, 0, 0, 0, 0, 16'h0000, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready in reset", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort in_ready after", 32'(in_ready), 32'd1);
    check("abort out_valid after", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send_word(0, 16'h3E00, 16'h3E00, 1, 0, 0, 1, 16'h409C, 4'b0000);

    // bf16 instance
    send_word(1, 16'h4000, 16'h4040, 0, 0, 0, 1, 16'h40C0, 4'b0000);
    send_word(1, 16'h3F80, 16'h3F80, 0, 0, 0, 1, 16'h3F80, 4'b0000);

    // Random fp16 operands against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom);
      r  = model16(ra, rb, rm);
      send_word(0, ra, rb, rm, int'($urandom_range(0, 1)), 0, 1, r[15:0], r[19:16]);
    end

    // Drain both scoreboards
    n = 0;
    while ((sb.size() != 0 || sb_b.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", 32'(sb.size() + sb_b.size()), 32'd0);
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
